// File: rtl/sad_pkg.sv
// Shared constants and loader state encoding for the SAD block.
// Keeps the loader depth and the datapath index bound in step.
package sad_pkg;

   localparam int SAD_DATA_W = 32;
   localparam int SAD_DEPTH  = 256;
   localparam int SAD_ADDR_W = 9;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      FIRE
   } ld_state_t;

endpackage

// File: rtl/sad_bank.sv
// One SAD operand bank: register array, one write port and one
// combinational read port that returns zero past the last word.
module sad_bank
   import sad_pkg::*;
#(
   parameter int DATA_W = SAD_DATA_W,
   parameter int DEPTH  = SAD_DEPTH,
   parameter int ADDR_W = SAD_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-2:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Array is deliberately not reset; contents only matter after a load.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // The top address bit marks index DEPTH and beyond, which read as zero.
   always_comb begin
      rdata = '0;
      if (!raddr[ADDR_W-1])
         rdata = mem[raddr[ADDR_W-2:0]];
   end

endmodule

// File: rtl/sad_mem_loader.sv
// Streams 2*DEPTH words into banks A then B and pulses go when both
// are full; exposes both banks on a shared combinational read port.
module sad_mem_loader
   import sad_pkg::*;
#(
   parameter int DATA_W = SAD_DATA_W,
   parameter int DEPTH  = SAD_DEPTH,
   parameter int ADDR_W = SAD_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] dataA,
   output logic [DATA_W-1:0] dataB,
   output logic              go,
   output logic              busy,
   output logic              loaded
);

   localparam int IDX_W = $clog2(DEPTH);

   ld_state_t        state;
   ld_state_t        state_nx;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] wr_idx_nx;
   logic             loaded_nx;
   logic             last;
   logic             we_a;
   logic             we_b;

   assign last = (wr_idx == IDX_W'(DEPTH - 1));

   // State, write index and completion flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         wr_idx <= '0;
         loaded <= 1'b0;
      end else begin
         state  <= state_nx;
         wr_idx <= wr_idx_nx;
         loaded <= loaded_nx;
      end
   end

   // Next state, handshake and bank write enables.
   always_comb begin
      state_nx  = state;
      wr_idx_nx = wr_idx;
      loaded_nx = loaded;
      in_ready  = 1'b0;
      busy      = 1'b0;
      go        = 1'b0;
      we_a      = 1'b0;
      we_b      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx  = LOAD_A;
               wr_idx_nx = '0;
               loaded_nx = 1'b0;
            end
         end
         LOAD_A: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               we_a      = 1'b1;
               wr_idx_nx = wr_idx + 1'b1;
               if (last)
                  state_nx = LOAD_B;
            end
         end
         LOAD_B: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               we_b      = 1'b1;
               wr_idx_nx = wr_idx + 1'b1;
               if (last)
                  state_nx = FIRE;
            end
         end
         FIRE: begin
            go        = 1'b1;
            state_nx  = IDLE;
            loaded_nx = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   sad_bank #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_bank_a (
      .clk  (clk),
      .we   (we_a),
      .waddr(wr_idx),
      .wdata(in_data),
      .raddr(addr),
      .rdata(dataA)
   );

   sad_bank #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_bank_b (
      .clk  (clk),
      .we   (we_b),
      .waddr(wr_idx),
      .wdata(in_data),
      .raddr(addr),
      .rdata(dataB)
   );

endmodule

// File: tb/tb_sad_mem_loader.sv
// Directed bench for sad_mem_loader: loads, gaps, reset, start hold.
module tb_sad_mem_loader;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic [8:0]  addr = '0;
   logic [31:0] dataA;
   logic [31:0] dataB;
   logic        go;
   logic        busy;
   logic        loaded;

   int total = 0;
   int bad = 0;
   int go_cnt = 0;

   sad_mem_loader dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .in_valid(in_valid),
      .in_data (in_data),
      .in_ready(in_ready),
      .addr    (addr),
      .dataA   (dataA),
      .dataB   (dataB),
      .go      (go),
      .busy    (busy),
      .loaded  (loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (go)
         go_cnt <= go_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic rd(input logic [8:0] a, input logic [31:0] ea,
                     input logic [31:0] eb);
      addr = a;
      #1;
      check($sformatf("dataA[%0d]", a), dataA, ea);
      check($sformatf("dataB[%0d]", a), dataB, eb);
   endtask

   // Entered at posedge+1 in IDLE; returns at posedge+1 after the
   // FIRE edge, or right after `limit` transfers for a partial load.
   task automatic load(input logic [31:0] base, input bit gaps,
                       input bit hold, input int limit,
                       output int go_cyc, output int rdy_n,
                       output logic busy_go);
      int sent;
      int cyc;
      logic r;
      go_cyc = -1;
      rdy_n = 0;
      busy_go = 1'b1;
      sent = 0;
      cyc = 0;
      start = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      if (!hold)
         start = 1'b0;
      while (cyc < 3000) begin
         cyc++;
         in_valid = (sent < limit) &&
                    (!gaps || ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3));
         in_data = base + 32'(sent);
         @(negedge clk);
         r = in_ready;
         if (r)
            rdy_n++;
         if (go && go_cyc < 0) begin
            go_cyc = cyc;
            busy_go = busy | in_ready;
         end
         @(posedge clk);
         #1;
         if (in_valid && r)
            sent++;
         if (go_cyc >= 0 || (limit < 2 * DEPTH && sent == limit))
            break;
      end
      in_valid = 1'b0;
      check("load_in_budget", 32'(cyc < 3000), 32'd1);
   endtask

   initial begin
      int gc;
      int rn;
      logic bg;
      int g0;

      #12;
      check("rst_in_ready", in_ready, 0);
      check("rst_go", go, 0);
      check("rst_busy", busy, 0);
      check("rst_loaded", loaded, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // back-to-back load, in_data = i
      g0 = go_cnt;
      load(32'h0, 1'b0, 1'b0, 512, gc, rn, bg);
      check("b2b_go_cycle", gc, 513);
      check("b2b_ready_cycles", rn, 512);
      check("b2b_fire_busy_ready", bg, 0);
      check("b2b_go_count", go_cnt - g0, 1);
      check("b2b_loaded", loaded, 1);
      rd(9'd5, 32'd5, 32'd261);
      rd(9'd255, 32'd255, 32'd511);
      rd(9'd256, 32'd0, 32'd0);
      rd(9'd511, 32'd0, 32'd0);

      // backpressure pattern 1,0,0,1
      g0 = go_cnt;
      load(32'hA000_0000, 1'b1, 1'b0, 512, gc, rn, bg);
      check("gap_go_count", go_cnt - g0, 1);
      check("gap_loaded", loaded, 1);
      for (int i = 0; i < DEPTH; i++)
         rd(9'(i), 32'hA000_0000 + 32'(i), 32'hA000_0100 + 32'(i));
      rd(9'd0, 32'hA000_0000, 32'hA000_0100);

      // reset after 300 transfers, asserted between edges
      g0 = go_cnt;
      load(32'hC000_0000, 1'b0, 1'b0, 300, gc, rn, bg);
      check("mid_busy_before", busy, 1);
      #3;
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_go", go, 0);
      check("mid_rst_loaded", loaded, 0);
      #2;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_no_go", go_cnt - g0, 0);
      check("mid_idle_busy", busy, 0);
      rd(9'd0, 32'hC000_0000, 32'hC000_0100);
      rd(9'd43, 32'hC000_002B, 32'hC000_012B);
      rd(9'd44, 32'hC000_002C, 32'hA000_012C);

      // fresh load after reset
      g0 = go_cnt;
      load(32'h5000_0000, 1'b0, 1'b0, 512, gc, rn, bg);
      check("fresh_go_cycle", gc, 513);
      check("fresh_go_count", go_cnt - g0, 1);
      check("fresh_loaded", loaded, 1);
      rd(9'd7, 32'h5000_0007, 32'h5000_0107);
      rd(9'd200, 32'h5000_00C8, 32'h5000_01C8);

      // start held through load and FIRE
      g0 = go_cnt;
      load(32'h0, 1'b0, 1'b1, 512, gc, rn, bg);
      check("hold_go_cycle", gc, 513);
      check("hold_go_count", go_cnt - g0, 1);
      check("hold_idle_loaded", loaded, 1);
      check("hold_idle_busy", busy, 0);
      @(posedge clk);
      #1;
      check("hold_restart_loaded", loaded, 0);
      check("hold_restart_busy", busy, 1);
      start = 1'b0;
      rst = 1'b1;
      #2;
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sad_mem_loader.md
Name: sad_mem_loader

Overview:
- Writer side of the SAD operand memories. It accepts a valid/ready word stream and fills bank A with 256 words, then bank B with 256 words.
- After both banks are full it pulses `go` to the SAD FSM.
- Exposes the combinational read port that the SAD datapath drives with `ab_addr`. Replaces the fixed test ROM when real image blocks are loaded.

Parameters:
- DATA_W, 32, width of one pixel word in banks A and B
- DEPTH, 256, words per bank; must be a power of two
- ADDR_W, 9, read address width; one bit wider than log2(DEPTH) so the datapath can present index DEPTH

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a new load; sampled only in IDLE
- in_valid  input  1  in_data holds a valid word
- in_data  input  DATA_W  stream word; the first DEPTH words go to bank A, the next DEPTH to bank B
- in_ready  output  1  loader accepts a word this cycle
- addr  input  ADDR_W  read address from the SAD datapath
- dataA  output  DATA_W  bank A word at addr (combinational)
- dataB  output  DATA_W  bank B word at addr (combinational)
- go  output  1  single-cycle pulse; both banks are complete
- busy  output  1  load in progress (LOAD_A or LOAD_B)
- loaded  output  1  banks hold a complete, unbroken data set

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - state = IDLE, wr_idx = 0
  - in_ready = 0, go = 0, busy = 0, loaded = 0
  - memory arrays are NOT reset; contents are undefined until the first load.
- States: IDLE, LOAD_A, LOAD_B, FIRE.
- IDLE:
  - in_ready = 0.
  - start=1 -> LOAD_A, wr_idx = 0, loaded cleared to 0 in the same edge.
  - start=0 -> stay.
- LOAD_A:
  - in_ready = 1, busy = 1.
  - A transfer is in_valid & in_ready. On a transfer, memA[wr_idx] <= in_data and wr_idx++.
  - A transfer at wr_idx = DEPTH-1 -> LOAD_B with wr_idx = 0.
  - in_valid=0 -> hold state and index; no timeout.
- LOAD_B:
  - Same as LOAD_A, but writes memB.
  - A transfer at wr_idx = DEPTH-1 -> FIRE.
- FIRE:
  - go = 1 for exactly this cycle, in_ready = 0, busy = 0.
  - Next edge -> IDLE and loaded <= 1.
- Throughput: one word per cycle. A full load takes 2*DEPTH transfer cycles plus 1 FIRE cycle; go is high on cycle 2*DEPTH+1 after the start edge when in_valid is held high.
- start:
  - Ignored outside IDLE; it never restarts a load in progress.
  - start asserted in the same cycle as FIRE has no effect.
  - start high in the IDLE cycle after FIRE begins a new load and clears loaded.
- Read port:
  - Combinational from the register arrays using addr[ADDR_W-2:0].
  - addr >= DEPTH (addr[ADDR_W-1]=1) returns 0 on both dataA and dataB.
  - A write at edge N is visible on dataA/dataB after edge N; there is no write-through bypass.
  - Reads during a load are legal and return the current mixed contents; loaded=0 flags this state.
- Reset mid-load:
  - Returns to IDLE with loaded=0 and go never pulses.
  - Partially written data stays in the arrays.
- wr_idx:
  - Width log2(DEPTH).
  - Wraps naturally at DEPTH-1; the wrap coincides with the state change.

Decomposition:
- Shared package `sad_pkg`:
  - constants SAD_DATA_W=32, SAD_DEPTH=256, SAD_ADDR_W=9
  - the loader state enum (IDLE, LOAD_A, LOAD_B, FIRE)
  - these are shared with the SAD FSM and datapath so the i_lt_256 bound and the loader depth cannot diverge.
- One natural sub-module, `sad_bank`:
  - DEPTH x DATA_W register array with one synchronous write port (we, waddr, wdata) and one combinational read port with the out-of-range zeroing.
  - Instantiated twice, for A and B.
- The FSM and counter stay in sad_mem_loader.

Test Plan:
- Reset values: assert rst asynchronously mid-cycle -> in_ready, go, busy, loaded all 0 immediately, without waiting for a clk edge.
- Back-to-back load: start=1, then in_valid=1 with in_data=i for i=0..511 -> in_ready high 512 cycles, go pulses once on cycle 513, loaded=1 next cycle. Then addr=5 -> dataA=5, dataB=261; addr=255 -> dataA=255, dataB=511.
- Backpressure gaps: in_valid toggling 1,0,0,1 through the whole load with words 0xA0000000+i -> exactly 512 writes, no skips or duplicates. Final dataB at addr=0 is 0xA0000100.
- Out-of-range read: after a load, addr=256 -> dataA=0, dataB=0. addr=511 -> 0.
- Reset mid-load: rst pulse after 300 transfers -> state IDLE, go never asserts, loaded=0. A fresh start plus 512 words then completes normally with correct contents.
- start ignored: start held high through an entire load and through FIRE -> exactly one go pulse per accepted start. A second load begins only from the IDLE cycle after FIRE, and loaded drops to 0 at that start edge.
